// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: detects ecall/ebreak/illegal/interrupt/mret in EX and sequences CSR writes and the fetch redirect.
// Optional feature: define TRAP_MTVAL_EN to add the SAVE_TVAL state and mtval write.
module trap_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_instr,
    input  logic        ex_ecall,
    input  logic        ex_ebreak,
    input  logic        ex_mret,
    input  logic        ex_illegal,
    input  logic [1:0]  ex_csr_op,
    input  logic        irq_ext,
    input  logic [31:0] csr_mstatus,
    input  logic [31:0] csr_mie,
    input  logic [31:0] csr_mtvec,
    input  logic [31:0] csr_mepc,
    output logic [1:0]  csr_op_gated,
    output logic        trap_we,
    output logic [11:0] trap_waddr,
    output logic [31:0] trap_wdata,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam logic [1:0]  CSR_OP_NONE = 2'b00;
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SAVE_STATUS, RESTORE_STATUS, REDIRECT
    } state_t;

    state_t state, state_d;

    logic        irq_take, trap_det, mret_det;
    logic [31:0] cause_d, cause_r;
    logic        mret_r;
    logic        flush_r;

    logic        we_d, stall_d, rv_d, flush_d;
    logic [11:0] waddr_d;
    logic [31:0] wdata_d, rpc_d;

    function automatic logic [31:0] trap_status(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_status(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    function automatic logic [31:0] trap_target(input logic [31:0] tvec, input logic [31:0] cause);
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        if (tvec[1:0] == 2'b01 && cause[31])
            base = base + 32'd44;
        return base;
    endfunction

    assign irq_take = irq_ext & csr_mstatus[3] & csr_mie[11];
    assign trap_det = (state == IDLE) & ex_valid & (ex_illegal | ex_ebreak | ex_ecall | irq_take);
    assign mret_det = (state == IDLE) & ex_valid & ex_mret & ~trap_det;

    always_comb begin
        cause_d = 32'h8000_000B;
        if (ex_illegal)     cause_d = 32'd2;
        else if (ex_ebreak) cause_d = 32'd3;
        else if (ex_ecall)  cause_d = 32'd11;
    end

    assign csr_op_gated = (state == IDLE && !trap_det && !mret_det) ? ex_csr_op : CSR_OP_NONE;
    assign flush_o      = trap_det | mret_det | flush_r;

`ifdef TRAP_MTVAL_EN
    logic [31:0] tval_d, tval_r;

    always_comb begin
        tval_d = 32'h0;
        if (ex_illegal)     tval_d = ex_instr;
        else if (ex_ebreak) tval_d = ex_pc;
    end

    always_ff @(posedge clk)
        if (trap_det) tval_r <= tval_d;

    logic unused_inputs;
    assign unused_inputs = ^{csr_mie[31:12], csr_mie[10:0]};
`else
    logic unused_inputs;
    assign unused_inputs = ^{csr_mie[31:12], csr_mie[10:0], ex_instr};
`endif

    // Trap context captured at detect; epc is written straight from ex_pc on the next cycle.
    always_ff @(posedge clk)
        if (trap_det | mret_det) begin
            cause_r <= cause_d;
            mret_r  <= mret_det;
        end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_d;

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (trap_det)      state_d = SAVE_EPC;
                else if (mret_det) state_d = RESTORE_STATUS;
            end
            SAVE_EPC:       state_d = SAVE_CAUSE;
`ifdef TRAP_MTVAL_EN
            SAVE_CAUSE:     state_d = SAVE_TVAL;
            SAVE_TVAL:      state_d = SAVE_STATUS;
`else
            SAVE_CAUSE:     state_d = SAVE_STATUS;
`endif
            SAVE_STATUS:    state_d = REDIRECT;
            RESTORE_STATUS: state_d = REDIRECT;
            REDIRECT:       state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered in that state's cycle.
    always_comb begin
        we_d    = 1'b0;
        waddr_d = 12'h0;
        wdata_d = 32'h0;
        stall_d = 1'b0;
        rv_d    = 1'b0;
        flush_d = 1'b0;
        rpc_d   = RESET_VECTOR;
        case (state_d)
            SAVE_EPC: begin
                we_d = 1'b1; waddr_d = ADDR_MEPC; wdata_d = ex_pc; stall_d = 1'b1;
            end
            SAVE_CAUSE: begin
                we_d = 1'b1; waddr_d = ADDR_MCAUSE; wdata_d = cause_r; stall_d = 1'b1;
            end
`ifdef TRAP_MTVAL_EN
            SAVE_TVAL: begin
                we_d = 1'b1; waddr_d = ADDR_MTVAL; wdata_d = tval_r; stall_d = 1'b1;
            end
`endif
            SAVE_STATUS: begin
                we_d = 1'b1; waddr_d = ADDR_MSTATUS; wdata_d = trap_status(csr_mstatus); stall_d = 1'b1;
            end
            RESTORE_STATUS: begin
                we_d = 1'b1; waddr_d = ADDR_MSTATUS; wdata_d = mret_status(csr_mstatus); stall_d = 1'b1;
            end
            REDIRECT: begin
                rv_d    = 1'b1;
                flush_d = 1'b1;
                rpc_d   = mret_r ? csr_mepc : trap_target(csr_mtvec, cause_r);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            trap_we        <= 1'b0;
            trap_waddr     <= 12'h0;
            trap_wdata     <= 32'h0;
            stall_o        <= 1'b0;
            flush_r        <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_VECTOR;
        end else begin
            trap_we        <= we_d;
            trap_waddr     <= waddr_d;
            trap_wdata     <= wdata_d;
            stall_o        <= stall_d;
            flush_r        <= flush_d;
            redirect_valid <= rv_d;
            redirect_pc    <= rpc_d;
        end

endmodule
